// File: rtl/serial_add_ctrl_pkg.sv
// Shared encodings for the serial ADD unit and the multi-cycle control unit.
// FSM state codes and the add/subtract op code.
package serial_add_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_bit_cell.sv
// One-bit full adder cell, purely combinational.
// Latency 0; no flow control.
module add_bit_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ c_i;
  assign cout_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one operand bit pair per cycle, LSB first.
// Latency WIDTH+2 cycles start-to-done; start is ignored unless IDLE.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             carry_out_q;
  logic             overflow_q;
  logic             zero_q;

  logic sum_bit;
  logic cell_cout;

  add_bit_cell u_bit_cell (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .c_i    (carry_q),
    .s_o    (sum_bit),
    .cout_o (cell_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
            a_q         <= a_in;
            b_q         <= (op_sub == OP_SUB) ? ~b_in : b_in;
            carry_q     <= op_sub;
            cnt_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= RUN;
          end
        end
        RUN: begin
          result_q <= {sum_bit, result_q[WIDTH-1:1]};
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          carry_q  <= cell_cout;
          if (cnt_q == LAST_BIT) begin
            // carry_q here is the carry into the MSB
            carry_out_q <= cell_cout;
            overflow_q  <= carry_q ^ cell_cout;
            busy_q      <= 1'b0;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          zero_q  <= (result_q == '0);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule
